// File: rtl/uart_rx_line_monitor.sv
// UART receiver with 16x oversampling, line tagging and a {last, byte} FIFO.
// Optional stats counters: define UART_RX_LINE_MONITOR_STATS_EN.
module uart_rx_line_monitor #(
  parameter int unsigned ClkFreqHz = 20_000_000,
  parameter int unsigned BaudRate  = 115200,
  parameter bit          ParityEna = 1'b0,
  parameter int unsigned FifoDepth = 16,
  parameter int unsigned LineMax   = 80
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        rx_i,
  output logic [7:0]  data_o,
  output logic        last_o,
  output logic        valid_o,
  input  logic        ready_i,
  input  logic        clear_i,
  output logic        frame_err_o,
  output logic        parity_err_o,
  output logic        overflow_o,
  output logic [15:0] rx_bytes_o,
  output logic [7:0]  err_cnt_o
);
  localparam int unsigned DivRaw = ClkFreqHz / (BaudRate * 16);
  localparam int unsigned Div    = (DivRaw < 1) ? 1 : DivRaw;
  localparam int unsigned DivW   = (Div > 1) ? $clog2(Div) : 1;
  localparam int unsigned PtrW   = $clog2(FifoDepth);
  localparam int unsigned LineW  = $clog2(LineMax + 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;
  typedef struct packed {
    logic       last;
    logic [7:0] data;
  } entry_t;

  state_e          state_q, state_d;
  logic            rx_s1, rx_s2, rx_q, fall;
  logic [DivW-1:0] div_cnt;
  logic            tick, smp;
  logic [3:0]      tick_cnt;
  logic [2:0]      bit_cnt;
  logic [7:0]      shreg;
  logic            stop_bad;
  logic            push, frame_set, par_set, ovf_set;

  // Two-flop synchronizer plus one extra flop for edge detection
  always_ff @(posedge clk_i) begin
    if (!rst_ni) {rx_s1, rx_s2, rx_q} <= 3'b111;
    else begin
      rx_s1 <= rx_i;
      rx_s2 <= rx_s1;
      rx_q  <= rx_s2;
    end
  end
  assign fall = rx_q & ~rx_s2;

  assign tick = (div_cnt == DivW'(Div - 1));
  always_ff @(posedge clk_i) begin
    if (!rst_ni)                                   div_cnt <= '0;
    else if ((state_q == IDLE && fall) || tick)    div_cnt <= '0;
    else                                           div_cnt <= div_cnt + 1'b1;
  end

  // START samples mid-bit (8 ticks); all later bits are one full bit apart
  assign smp = tick && (tick_cnt == ((state_q == START) ? 4'd7 : 4'd15));

  always_comb begin
    state_d   = state_q;
    push      = 1'b0;
    frame_set = 1'b0;
    par_set   = 1'b0;
    case (state_q)
      IDLE:   if (fall) state_d = START;
      START:  if (smp) state_d = rx_s2 ? IDLE : DATA;
      DATA:   if (smp && bit_cnt == 3'd7) state_d = ParityEna ? PARITY : STOP;
      PARITY: if (smp) begin
        par_set = (rx_s2 != ^shreg);
        state_d = STOP;
      end
      STOP: begin
        if (stop_bad) begin
          if (rx_s2) state_d = IDLE;
        end else if (smp) begin
          push      = rx_s2;
          frame_set = ~rx_s2;
          if (rx_s2) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      stop_bad <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_d != state_q) tick_cnt <= '0;
      else if (tick)          tick_cnt <= tick_cnt + 1'b1;
      if (state_d == DATA && state_q != DATA) bit_cnt <= '0;
      else if (state_q == DATA && smp)        bit_cnt <= bit_cnt + 1'b1;
      if (state_q == DATA && smp) shreg <= {rx_s2, shreg[7:1]};
      // Bad stop bit: hold in STOP until the line returns high
      if (frame_set)              stop_bad <= 1'b1;
      else if (state_q != STOP)   stop_bad <= 1'b0;
    end
  end

  // FIFO with an extra pointer bit to tell full from empty
  entry_t           mem [FifoDepth];
  logic [PtrW:0]    wr_ptr, rd_ptr;
  logic [LineW-1:0] line_cnt;
  logic             empty, full, pop, wr_ok, last_in;
  entry_t           head;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[PtrW] != rd_ptr[PtrW]) &&
                   (wr_ptr[PtrW-1:0] == rd_ptr[PtrW-1:0]);
  assign pop     = ~empty & ready_i;
  assign wr_ok   = push & (~full | pop);
  assign ovf_set = push & full & ~pop;
  assign last_in = (shreg == 8'h0A) || (line_cnt == LineW'(LineMax - 1));
  assign head    = mem[rd_ptr[PtrW-1:0]];

  always_ff @(posedge clk_i) begin
    if (wr_ok) mem[wr_ptr[PtrW-1:0]] <= '{last: last_in, data: shreg};
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      line_cnt <= '0;
    end else begin
      if (wr_ok) begin
        wr_ptr   <= wr_ptr + 1'b1;
        line_cnt <= last_in ? '0 : line_cnt + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  assign valid_o = ~empty;
  assign data_o  = empty ? 8'h00 : head.data;
  assign last_o  = ~empty & head.last;

  // Sticky flags: a new event wins over a same-cycle clear
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      frame_err_o  <= 1'b0;
      parity_err_o <= 1'b0;
      overflow_o   <= 1'b0;
    end else begin
      if (frame_set)    frame_err_o  <= 1'b1;
      else if (clear_i) frame_err_o  <= 1'b0;
      if (par_set)      parity_err_o <= 1'b1;
      else if (clear_i) parity_err_o <= 1'b0;
      if (ovf_set)      overflow_o   <= 1'b1;
      else if (clear_i) overflow_o   <= 1'b0;
    end
  end

`ifdef UART_RX_LINE_MONITOR_STATS_EN
  logic [15:0] rx_bytes_q;
  logic [7:0]  err_cnt_q;
  // Error events live in distinct cycles, so one increment per cycle suffices
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rx_bytes_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      if (push) rx_bytes_q <= rx_bytes_q + 1'b1;
      if ((frame_set | par_set | ovf_set) && err_cnt_q != 8'hFF)
        err_cnt_q <= err_cnt_q + 1'b1;
    end
  end
  assign rx_bytes_o = rx_bytes_q;
  assign err_cnt_o  = err_cnt_q;
`else
  assign rx_bytes_o = '0;
  assign err_cnt_o  = '0;
`endif

endmodule

// File: tb/tb_uart_rx_line_monitor.sv
// Bench: unit 0 = no parity, 4-deep FIFO; unit 1 = even parity, 16-deep FIFO.
module tb_uart_rx_line_monitor;
  localparam int BT = 32;  // clocks per bit (divisor 2)
  localparam int LM = 80;

  logic       clk = 0, rst_n = 0;
  logic       rx [2];
  logic       rdy_man [2];
  logic       ready_w [2];
  logic       clr [2];
  logic [7:0] dat [2];
  logic       lst [2], valid [2], ferr [2], perr [2], ovf [2];
  logic [15:0] rxb [2];
  logic [7:0]  errc [2];
  logic       rnd_on = 0, rnd_rdy = 0;

  int total = 0, bad = 0;
  logic [8:0] q0[$], q1[$];
  int  mline [2];
  bit  ef [2], ep [2], eo [2];
  int  popcnt [2], lastcnt [2];

  always #5 clk = ~clk;

  assign ready_w[0] = rdy_man[0];
  assign ready_w[1] = rnd_on ? rnd_rdy : rdy_man[1];

  uart_rx_line_monitor #(.ClkFreqHz(3_686_400), .BaudRate(115200), .ParityEna(1'b0),
                         .FifoDepth(4), .LineMax(LM)) u0 (
    .clk_i(clk), .rst_ni(rst_n), .rx_i(rx[0]), .data_o(dat[0]), .last_o(lst[0]),
    .valid_o(valid[0]), .ready_i(ready_w[0]), .clear_i(clr[0]), .frame_err_o(ferr[0]),
    .parity_err_o(perr[0]), .overflow_o(ovf[0]), .rx_bytes_o(rxb[0]), .err_cnt_o(errc[0]));

  uart_rx_line_monitor #(.ClkFreqHz(3_686_400), .BaudRate(115200), .ParityEna(1'b1),
                         .FifoDepth(16), .LineMax(LM)) u1 (
    .clk_i(clk), .rst_ni(rst_n), .rx_i(rx[1]), .data_o(dat[1]), .last_o(lst[1]),
    .valid_o(valid[1]), .ready_i(ready_w[1]), .clear_i(clr[1]), .frame_err_o(ferr[1]),
    .parity_err_o(perr[1]), .overflow_o(ovf[1]), .rx_bytes_o(rxb[1]), .err_cnt_o(errc[1]));

  task automatic chk(string nm, logic [15:0] act, logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int qsize(int u);
    return (u == 0) ? q0.size() : q1.size();
  endfunction

  task automatic wbit();
    repeat (BT) @(negedge clk);
  endtask

  // Reference: each good frame becomes one queue entry unless the FIFO is full
  task automatic model_push(int u, logic [7:0] d, bit stop_ok, int tl);
    bit l;
    if (!stop_ok) begin ef[u] = 1; return; end
    l = (tl < 0) ? ((d == 8'h0A) || (mline[u] == LM - 1)) : (tl != 0);
    if (qsize(u) >= ((u == 0) ? 4 : 16)) eo[u] = 1;
    else begin
      if (u == 0) q0.push_back({l, d}); else q1.push_back({l, d});
      mline[u] = l ? 0 : mline[u] + 1;
    end
  endtask

  task automatic send(int u, logic [7:0] d, bit par_ok, bit stop_ok, int tl);
    rx[u] = 0; wbit();
    for (int i = 0; i < 8; i++) begin rx[u] = d[i]; wbit(); end
    if (u == 1) begin
      rx[u] = (^d) ^ !par_ok; wbit();
      if (!par_ok) ep[u] = 1;
    end
    model_push(u, d, stop_ok, tl);
    rx[u] = stop_ok; wbit();
    rx[u] = 1; wbit();
  endtask

  task automatic drain(int u);
    int n = 0;
    while ((qsize(u) != 0 || valid[u]) && n < 4000) begin @(negedge clk); n++; end
    chk("drain_timeout", 16'(n < 4000), 16'd1);
  endtask

  task automatic clear(int u);
    clr[u] = 1; @(negedge clk); clr[u] = 0; @(negedge clk);
    ef[u] = 0; ep[u] = 0; eo[u] = 0;
  endtask

  // Pop checker: compares every accepted byte with the reference queue
  initial begin
    logic [8:0] e;
    forever begin
      @(negedge clk); #1;
      if (rst_n) for (int u = 0; u < 2; u++) if (valid[u] && ready_w[u]) begin
        popcnt[u]++;
        lastcnt[u] += int'(lst[u]);
        if (qsize(u) == 0) chk("unexpected_pop", {8'h0, dat[u]}, 16'hFFFF);
        else begin
          e = (u == 0) ? q0.pop_front() : q1.pop_front();
          chk("pop_data", 16'(dat[u]), 16'(e[7:0]));
          chk("pop_last", 16'(lst[u]), 16'(e[8]));
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    rnd_rdy = 1'($urandom_range(0, 1));
  end

  typedef struct {
    int u; logic [7:0] d; bit par_ok; bit stop_ok;
    bit last; bit ferr; bit perr; bit clr;
  } vec_t;
  vec_t tab [8];

  initial begin
    int p0, l0;
    tab[0] = '{0, 8'h48, 1, 1, 0, 0, 0, 0};
    tab[1] = '{0, 8'h69, 1, 1, 0, 0, 0, 0};
    tab[2] = '{0, 8'h0A, 1, 1, 1, 0, 0, 0};
    tab[3] = '{0, 8'h55, 1, 0, 0, 1, 0, 0};
    tab[4] = '{0, 8'h41, 1, 1, 0, 1, 0, 1};
    tab[5] = '{0, 8'h0A, 1, 1, 1, 0, 0, 0};
    tab[6] = '{1, 8'h07, 0, 1, 0, 0, 1, 1};
    tab[7] = '{1, 8'h0A, 1, 1, 1, 0, 0, 0};
    for (int u = 0; u < 2; u++) begin
      rx[u] = 1; rdy_man[u] = 1; clr[u] = 0; mline[u] = 0;
      ef[u] = 0; ep[u] = 0; eo[u] = 0; popcnt[u] = 0; lastcnt[u] = 0;
    end
    repeat (5) @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      chk("rst_valid", 16'(valid[u]), 0);
      chk("rst_data", 16'(dat[u]), 0);
      chk("rst_flags", 16'({ferr[u], perr[u], ovf[u]}), 0);
    end
    rst_n = 1;
    repeat (4) @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      send(tab[i].u, tab[i].d, tab[i].par_ok, tab[i].stop_ok, int'(tab[i].last));
      drain(tab[i].u);
      chk("tab_ferr", 16'(ferr[tab[i].u]), 16'(tab[i].ferr));
      chk("tab_perr", 16'(perr[tab[i].u]), 16'(tab[i].perr));
      chk("tab_ovf", 16'(ovf[tab[i].u]), 0);
      if (i == 2) begin
`ifdef UART_RX_LINE_MONITOR_STATS_EN
        chk("stats_rx_bytes", rxb[0], 16'd3);
`else
        chk("stats_rx_bytes", rxb[0], 16'd0);
`endif
        chk("stats_err_cnt", 16'(errc[0]), 0);
      end
      if (tab[i].clr) begin
        clear(tab[i].u);
        chk("clr_flags", 16'({ferr[tab[i].u], perr[tab[i].u]}), 0);
      end
    end

    // Overflow: 5 bytes into a 4-deep FIFO with no consumer
    rdy_man[0] = 0;
    for (int i = 0; i < 5; i++) send(0, 8'h30 + 8'(i), 1, 1, -1);
    chk("ovf_flag", 16'(ovf[0]), 16'(eo[0]));
    chk("ovf_head", 16'(dat[0]), 16'h30);
    chk("ovf_valid", 16'(valid[0]), 1);
    p0 = popcnt[0];
    rdy_man[0] = 1;
    drain(0);
    chk("ovf_pops", 16'(popcnt[0] - p0), 16'd4);
    clear(0);
    chk("ovf_clr", 16'(ovf[0]), 0);
    send(0, 8'h0A, 1, 1, -1);
    drain(0);

    // Line limit: 81 'a' bytes, only the 80th tagged last
    l0 = lastcnt[0];
    for (int i = 0; i < 81; i++) send(0, 8'h61, 1, 1, -1);
    drain(0);
    chk("line_last_count", 16'(lastcnt[0] - l0), 16'd1);

    // False start: 3-clock glitch
    p0 = popcnt[0];
    rx[0] = 0; repeat (3) @(negedge clk); rx[0] = 1;
    repeat (3 * BT) @(negedge clk);
    chk("glitch_pops", 16'(popcnt[0] - p0), 0);
    chk("glitch_valid", 16'(valid[0]), 0);
    chk("glitch_flags", 16'({ferr[0], ovf[0]}), 0);

    // Random frames on the parity unit with a random consumer
    clear(1);
    rnd_on = 1;
    for (int i = 0; i < 30; i++)
      send(1, 8'($urandom), $urandom_range(0, 7) != 0, $urandom_range(0, 7) != 0, -1);
    rnd_on = 0;
    drain(1);
    chk("rnd_ferr", 16'(ferr[1]), 16'(ef[1]));
    chk("rnd_perr", 16'(perr[1]), 16'(ep[1]));
    chk("rnd_ovf", 16'(ovf[1]), 16'(eo[1]));

    // Reset mid-frame with a held byte and a sticky error
    rdy_man[0] = 0;
    send(0, 8'h55, 1, 0, -1);
    send(0, 8'h33, 1, 1, -1);
    chk("pre_rst_state", 16'({valid[0], ferr[0]}), 16'b11);
    rx[0] = 0; wbit();
    for (int i = 0; i < 3; i++) begin rx[0] = 0; wbit(); end
    rx[0] = 1; repeat (BT / 2) @(negedge clk);
    rst_n = 0; @(negedge clk); rst_n = 1;
    q0.delete(); q1.delete();
    for (int u = 0; u < 2; u++) begin mline[u] = 0; ef[u] = 0; ep[u] = 0; eo[u] = 0; end
    chk("midrst_valid", 16'(valid[0]), 0);
    chk("midrst_data", 16'({lst[0], dat[0]}), 0);
    chk("midrst_flags", 16'({ferr[0], perr[0], ovf[0]}), 0);
    chk("midrst_stats", rxb[0] | 16'(errc[0]), 0);
    repeat (6 * BT) @(negedge clk);
    chk("midrst_nobyte", 16'(valid[0]), 0);
    rdy_man[0] = 1;
    p0 = popcnt[0];
    send(0, 8'h5A, 1, 1, -1);
    drain(0);
    chk("post_rst_pops", 16'(popcnt[0] - p0), 16'd1);
    chk("post_rst_flags", 16'({ferr[0], ovf[0]}), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uart_rx_line_monitor.md
Name: uart_rx_line_monitor

Overview:
- Synthesizable UART receiver that consumes the SoC's serial output (uart_tx_o of croc_soc) and deserializes it into bytes.
- Buffers received bytes in a small FIFO and tags the last byte of each text line.
- Intended placement: behind the SoC UART in FPGA/emulation builds or in a standalone test harness. It replaces the behavioural UART read task with a cycle-accurate, checkable stage.
- Reports framing and parity errors and FIFO overflow.

Parameters:
- ClkFreqHz, 20_000_000, system clock frequency in Hz.
- BaudRate, 115200, line rate. Divisor = ClkFreqHz/(BaudRate*16), integer truncation, minimum 1.
- ParityEna, 0, 1 = an even parity bit is expected after the data bits.
- FifoDepth, 16, byte FIFO entries. Must be a power of 2, at least 2.
- LineMax, 80, byte count at which a line is force-terminated.

Ports:
- clk_i  in  1  system clock.
- rst_ni  in  1  reset, synchronous, active-low.
- rx_i  in  1  serial input, asynchronous to clk_i. Idle level is 1.
- data_o  out  8  received byte at the FIFO head.
- last_o  out  1  data_o is the final byte of a line.
- valid_o  out  1  FIFO not empty.
- ready_i  in  1  consumer accepts data_o. A pop happens when valid_o and ready_i are both 1.
- clear_i  in  1  clears the sticky error flags.
- frame_err_o  out  1  sticky: a stop bit was sampled as 0.
- parity_err_o  out  1  sticky: parity mismatch.
- overflow_o  out  1  sticky: a byte was dropped because the FIFO was full.
- rx_bytes_o  out  16  received-byte counter (optional feature).
- err_cnt_o  out  8  error counter (optional feature).

Behaviour:
- Reset (rst_ni sampled 0 on a clk_i edge):
  - All outputs go to 0; the FIFO empties; the line counter and the tick divider return to 0; the FSM enters IDLE.
  - A frame in progress when reset occurs is discarded.
- Input path: rx_i passes through a 2-flop synchronizer, reset value 1. All edge detection and sampling use the synchronized value.
- Tick generator: free-running counter that produces a one-cycle tick every Divisor clocks (16x oversampling).
  - The counter restarts at 0 when the FSM leaves IDLE, so sampling is phase-aligned to the start edge.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE -> START on a synchronized 1->0 transition.
  - START: after 8 ticks, sample rx. If it is 0, go to DATA. If it is 1, it is a false start: return to IDLE with no error.
  - DATA: sample every 16 ticks, 8 samples, LSB first. Then go to PARITY if ParityEna=1, otherwise STOP.
  - PARITY: sample after 16 ticks. If sample != XOR of the 8 data bits, set parity_err_o; the byte is still pushed. Then go to STOP.
  - STOP: sample after 16 ticks.
    - Sample 0: set frame_err_o, discard the byte, return to IDLE only once rx reads 1.
    - Sample 1: push the byte, return to IDLE.
- Line tagging:
  - last = 1 when byte == 0x0A, or when the line counter reaches LineMax-1 (this byte is the LineMax-th).
  - The line counter resets to 0 after any byte pushed with last=1; otherwise it increments on each push.
  - A dropped byte does not advance the line counter.
- FIFO:
  - Stores {last, byte}.
  - Push to an empty FIFO: valid_o is 1 on the cycle after the stop-bit sample (latency 1).
  - Push while full with no pop: the byte is dropped and overflow_o is set.
  - Push while full with a simultaneous pop: the push is accepted and no overflow is flagged.
  - Pop while empty: ignored.
  - Pointers wrap modulo FifoDepth; a count bit distinguishes full from empty.
- Sticky flags:
  - Set has priority over clear_i in the same cycle.
  - clear_i has no effect on the FIFO or the FSM.

Optional Feature:
- Macro: UART_RX_LINE_MONITOR_STATS_EN.
- Defined:
  - rx_bytes_o counts pushed bytes, including dropped ones, and wraps at 2^16.
  - err_cnt_o counts frame, parity and overflow events; it saturates at 255.
  - Both counters reset to 0 on reset only, not on clear_i.
- Undefined: rx_bytes_o and err_cnt_o are tied to 0 and no counter flops are synthesized.

Test Plan:
- Basic line: ClkFreqHz=20e6, BaudRate=115200 (Divisor 10, 160 clk/bit), ready_i=1, send "Hi\n". Expected: three pops with data_o 0x48, 0x69, 0x0A and last_o 0, 0, 1; no error flags set.
- Framing error: send 0x55 with the stop bit held 0 for 1 bit, then release. Expected: frame_err_o=1, no byte pushed. A following 0x41 is received correctly. clear_i pulse -> frame_err_o=0.
- Parity: ParityEna=1, send 0x07 with parity bit 0 (correct value is 1). Expected: parity_err_o=1, and the byte 0x07 is still popped.
- Overflow: FifoDepth=4, ready_i=0, send 5 bytes 0x30..0x34. Expected: FIFO holds 0x30..0x33, overflow_o=1. Then set ready_i=1 -> exactly 4 pops.
- Line limit / false start: LineMax=80, send 81 bytes of 0x61. Expected: byte 80 has last_o=1, byte 81 has last_o=0. A 3-clock low glitch on rx_i produces no byte and no error.
- Reset mid-frame: assert rst_ni=0 for 1 cycle during the 4th data bit. Expected: all outputs 0, no byte pushed, next full frame 0x5A received correctly. With STATS_EN defined, after the basic-line test: rx_bytes_o=3, err_cnt_o=0.
